// File: rtl/spi_slave_pkg.sv
// Shared encodings for the SPI responder: frame states, clock/select polarity codes, filler bit.
package spi_slave_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } frame_state_t;

   localparam logic CPOL_IDLE_LOW      = 1'b0;
   localparam logic CPHA_SAMPLE_LEAD   = 1'b0;
   localparam logic CSPOL_ACTIVE_HIGH  = 1'b1;
   localparam logic FILLER_BIT         = 1'b1;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an edge-detect flop
// giving single-cycle rise/fall pulses aligned with the synchronised level.
module spi_slave_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: synchronises SCLK/CS/MOSI, deserialises words, serialises a host-loaded word on MISO.
// Optional SPI_SLAVE_LSB_FIRST_EN adds i_lsb_first for LSB-first shifting in both directions.
module spi_slave
   import spi_slave_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] FILLER      = {WIDTH{FILLER_BIT}}
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_cpol,
   input  logic             i_cpha,
   input  logic             i_cspol,
`ifdef SPI_SLAVE_LSB_FIRST_EN
   input  logic             i_lsb_first,
`endif
   input  logic [WIDTH-1:0] i_tx_data,
   input  logic             i_tx_load,
   output logic             o_tx_ready,
   output logic             o_tx_underrun,
   output logic [WIDTH-1:0] o_rx_data,
   output logic             o_rx_valid,
   output logic             o_busy,
   input  logic             i_spi_clock,
   input  logic             i_spi_mosi,
   input  logic             i_spi_cs,
   output logic             o_spi_miso,
   output logic             o_miso_oe
);

   localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
   logic w_cs_lvl, w_cs_rise, w_cs_fall;
   logic w_mosi, w_mosi_rise, w_mosi_fall;
   logic w_unused_edges;

   spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_clock),
      .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

   spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_cs),
      .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

   spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .i_clock(i_clock), .i_reset(i_reset), .i_async(i_spi_mosi),
      .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

   assign w_unused_edges = w_mosi_rise | w_mosi_fall | w_sclk_lvl;

   logic w_lsb;
`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign w_lsb = i_lsb_first;
`else
   assign w_lsb = 1'b0;
`endif

   logic w_cs_on, w_cs_assert, w_lead, w_trail;
   assign w_cs_on     = (i_cspol == CSPOL_ACTIVE_HIGH) ? w_cs_lvl  : ~w_cs_lvl;
   assign w_cs_assert = (i_cspol == CSPOL_ACTIVE_HIGH) ? w_cs_rise : w_cs_fall;
   assign w_lead      = (i_cpol == CPOL_IDLE_LOW) ? w_sclk_rise : w_sclk_fall;
   assign w_trail     = (i_cpol == CPOL_IDLE_LOW) ? w_sclk_fall : w_sclk_rise;

   frame_state_t     r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rx_sh, r_rx_data, r_tx_sh, r_hold;
   logic             r_rx_valid, r_hold_full, r_underrun;
   logic             w_sample, w_load, w_shift, w_drop, w_shift_edge;

   // Entry needs an observed assert edge, so a line already asserted out of reset is not a frame.
   always_comb begin
      w_state_n    = r_state;
      w_sample     = 1'b0;
      w_load       = 1'b0;
      w_shift      = 1'b0;
      w_drop       = 1'b0;
      w_shift_edge = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cs_assert) begin
               w_state_n = ST_ACTIVE;
               w_load    = (i_cpha == CPHA_SAMPLE_LEAD);
            end
         end
         ST_ACTIVE: begin
            if (!w_cs_on) begin
               w_state_n = ST_IDLE;
               w_drop    = 1'b1;
            end else begin
               w_sample     = (i_cpha == CPHA_SAMPLE_LEAD) ? w_lead  : w_trail;
               w_shift_edge = (i_cpha == CPHA_SAMPLE_LEAD) ? w_trail : w_lead;
               w_load       = w_shift_edge && (r_cnt == '0);
               w_shift      = w_shift_edge && (r_cnt != '0);
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   logic [WIDTH-1:0] w_rx_next, w_tx_next;
   assign w_rx_next = w_lsb ? {w_mosi, r_rx_sh[WIDTH-1:1]} : {r_rx_sh[WIDTH-2:0], w_mosi};
   assign w_tx_next = w_lsb ? {FILLER_BIT, r_tx_sh[WIDTH-1:1]} : {r_tx_sh[WIDTH-2:0], FILLER_BIT};

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_rx_sh     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_tx_sh     <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_rx_valid <= 1'b0;
         r_underrun <= 1'b0;
         if (w_drop) begin
            r_cnt   <= '0;
            r_rx_sh <= '0;
         end else if (w_sample) begin
            r_rx_sh <= w_rx_next;
            if (r_cnt == LAST) begin
               r_cnt      <= '0;
               r_rx_data  <= w_rx_next;
               r_rx_valid <= 1'b1;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         if (w_load) begin
            r_tx_sh    <= r_hold_full ? r_hold : FILLER;
            r_underrun <= ~r_hold_full;
         end else if (w_shift) begin
            r_tx_sh <= w_tx_next;
         end
         // A load into an empty holding reg in the same cycle as a load point lands after the filler.
         if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
         end else if (i_tx_load && !r_hold_full) begin
            r_hold      <= i_tx_data;
            r_hold_full <= 1'b1;
         end
      end
   end

   assign o_busy        = (r_state == ST_ACTIVE);
   assign o_miso_oe     = o_busy;
   assign o_spi_miso    = o_busy ? (w_lsb ? r_tx_sh[0] : r_tx_sh[WIDTH-1]) : 1'b1;
   assign o_tx_ready    = ~r_hold_full;
   assign o_tx_underrun = r_underrun;
   assign o_rx_data     = r_rx_data;
   assign o_rx_valid    = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: bench-driven SPI master, word-level reference model, random frames.
module tb_spi_slave;

   localparam int HP = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cpol, cpha, cspol, tx_load;
   logic [7:0] tx_data;
   logic       tx_ready, tx_underrun, rx_valid, busy, miso_oe;
   logic [7:0] rx_data;
   logic       spi_sclk, spi_mosi, spi_cs, spi_miso;
`ifdef SPI_SLAVE_LSB_FIRST_EN
   logic       lsb_first = 1'b0;
`endif

   always #5 clk = ~clk;

   spi_slave dut (
      .i_clock(clk), .i_reset(rst_n), .i_cpol(cpol), .i_cpha(cpha), .i_cspol(cspol),
`ifdef SPI_SLAVE_LSB_FIRST_EN
      .i_lsb_first(lsb_first),
`endif
      .i_tx_data(tx_data), .i_tx_load(tx_load), .o_tx_ready(tx_ready),
      .o_tx_underrun(tx_underrun), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
      .o_busy(busy), .i_spi_clock(spi_sclk), .i_spi_mosi(spi_mosi), .i_spi_cs(spi_cs),
      .o_spi_miso(spi_miso), .o_miso_oe(miso_oe));

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // monitor
   logic [7:0] rx_q[$];
   int         urun_cnt = 0;
   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_underrun) urun_cnt++;
   end

   // reference model: one holding slot, a word is taken from it at every load point
   logic [7:0] m_hold;
   bit         m_full = 1'b0;
   bit         m_lsb  = 1'b0;
   int         exp_urun;
   logic [7:0] exp_miso[$];
   logic [7:0] m_words[$];
   logic [7:0] got_miso[$];

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   task automatic mdl_load();
      if (m_full) begin
         exp_miso.push_back(m_hold);
         m_full = 1'b0;
      end else begin
         exp_miso.push_back(8'hFF);
         exp_urun++;
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
      if (!m_full) begin
         m_hold = d;
         m_full = 1'b1;
      end
      chk("tx_ready_after_load", tx_ready, !m_full);
   endtask

   task automatic set_mode(input logic cp, input logic ph, input logic cs);
      cpol = cp; cpha = ph; cspol = cs;
      spi_sclk = cp;
      spi_cs = ~cs;
      wait_clk(2 * HP);
   endtask

   // stop_bits < 0: full frame; do_rst: pulse reset at the stop point
   task automatic frame(input string tag, input int stop_bits, input bit do_rst);
      int         nbits, done_words, urun_base;
      bit         stopped;
      logic [7:0] cur, e;
      nbits = 0; stopped = 0; exp_urun = 0;
      got_miso.delete(); exp_miso.delete(); rx_q.delete();
      urun_base = urun_cnt;
      spi_mosi = m_words[0][7];
      wait_clk(HP);
      spi_cs = cspol;
      if (!cpha) mdl_load();
      wait_clk(HP + 2);
      for (int w = 0; w < m_words.size() && !stopped; w++) begin
         cur = 8'h00;
         for (int b = 7; b >= 0; b--) begin
            if (cpha) begin
               if (b == 7) mdl_load();
               spi_sclk = ~cpol;
               spi_mosi = m_words[w][b];
               wait_clk(HP);
               cur[b] = spi_miso;
               spi_sclk = cpol;
               wait_clk(HP);
            end else begin
               cur[b] = spi_miso;
               spi_sclk = ~cpol;
               wait_clk(HP);
               spi_sclk = cpol;
               if (b > 0) spi_mosi = m_words[w][b-1];
               else if (w + 1 < m_words.size()) spi_mosi = m_words[w+1][7];
               if (b == 0) mdl_load();
               wait_clk(HP);
            end
            nbits++;
            if (nbits == stop_bits) begin
               stopped = 1;
               break;
            end
         end
         if (!stopped) got_miso.push_back(cur);
      end
      if (do_rst) begin
         @(negedge clk);
         rst_n = 1'b0;
         #1;
         chk({tag, "_rst_tx_ready"}, tx_ready, 1);
         chk({tag, "_rst_underrun"}, tx_underrun, 0);
         chk({tag, "_rst_rx_data"}, rx_data, 0);
         chk({tag, "_rst_rx_valid"}, rx_valid, 0);
         chk({tag, "_rst_busy"}, busy, 0);
         chk({tag, "_rst_miso"}, spi_miso, 1);
         chk({tag, "_rst_oe"}, miso_oe, 0);
         spi_cs = ~cspol;
         wait_clk(3);
         m_full = 1'b0;
         rst_n = 1'b1;
         wait_clk(2 * HP);
      end else begin
         wait_clk(HP);
         spi_cs = ~cspol;
         wait_clk(2 * HP + 4);
      end
      done_words = (stop_bits < 0) ? m_words.size() : stop_bits / 8;
      chk({tag, "_rx_count"}, rx_q.size(), done_words);
      for (int i = 0; i < rx_q.size() && i < done_words; i++) begin
         e = m_lsb ? rev8(m_words[i]) : m_words[i];
         chk($sformatf("%s_rx%0d", tag, i), rx_q[i], e);
      end
      for (int i = 0; i < got_miso.size() && i < exp_miso.size(); i++) begin
         e = m_lsb ? rev8(exp_miso[i]) : exp_miso[i];
         chk($sformatf("%s_miso%0d", tag, i), got_miso[i], e);
      end
      chk({tag, "_underruns"}, urun_cnt - urun_base, exp_urun);
      chk({tag, "_tx_ready"}, tx_ready, !m_full);
      chk({tag, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      int nw, sb;
      cpol = 0; cpha = 0; cspol = 1; tx_load = 0; tx_data = 0;
      spi_sclk = 0; spi_cs = 0; spi_mosi = 0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      chk("reset_tx_ready", tx_ready, 1);
      chk("reset_underrun", tx_underrun, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_miso", spi_miso, 1);
      chk("reset_oe", miso_oe, 0);

      // mode 0, preloaded A5, master sends 3C
      set_mode(0, 0, 1);
      load_tx(8'hA5);
      m_words = '{8'h3C};
      frame("t1", -1, 0);
      if (got_miso.size() == 1) chk("t1_miso_a5", got_miso[0], 8'hA5);
      else chk("t1_miso_words", got_miso.size(), 1);
      chk("t1_rx_data", rx_data, 8'h3C);

      // mode 3, two words, only the first preloaded
      set_mode(1, 1, 1);
      load_tx(8'h5A);
      m_words = '{8'h01, 8'h80};
      frame("t2", -1, 0);
      if (got_miso.size() == 2) chk("t2_miso_filler", got_miso[1], 8'hFF);
      else chk("t2_miso_words", got_miso.size(), 2);
      chk("t2_rx_data", rx_data, 8'h80);

      // partial frame then full word
      set_mode(0, 0, 1);
      m_words = '{8'hAA};
      frame("t3a", 5, 0);
      m_words = '{8'h55};
      frame("t3b", -1, 0);
      chk("t3_rx_data", rx_data, 8'h55);

      // second load while holding reg full is ignored
      load_tx(8'h11);
      load_tx(8'h22);
      chk("t4_tx_ready_low", tx_ready, 0);
      m_words = '{8'($urandom)};
      frame("t4", -1, 0);
      if (got_miso.size() == 1) chk("t4_miso_11", got_miso[0], 8'h11);
      else chk("t4_miso_words", got_miso.size(), 1);

      // reset mid-word, then a clean frame
      load_tx(8'h3E);
      m_words = '{8'hC3};
      frame("t5a", 4, 1);
      load_tx(8'h96);
      m_words = '{8'h69};
      frame("t5b", -1, 0);

`ifdef SPI_SLAVE_LSB_FIRST_EN
      set_mode(0, 0, 1);
      lsb_first = 1'b1; m_lsb = 1'b1;
      load_tx(8'h01);
      m_words = '{8'h80};
      frame("t6", -1, 0);
      if (got_miso.size() == 1) chk("t6_miso_first", got_miso[0][7], 1'b1);
      chk("t6_rx_data", rx_data, 8'h01);
      lsb_first = 1'b0; m_lsb = 1'b0;
`endif

      // randomized frames
      for (int it = 0; it < 14; it++) begin
         set_mode(1'($urandom), 1'($urandom), 1'($urandom));
`ifdef SPI_SLAVE_LSB_FIRST_EN
         lsb_first = 1'($urandom); m_lsb = lsb_first;
`endif
         if ($urandom_range(0, 2) != 0) load_tx(8'($urandom));
         if ($urandom_range(0, 3) == 0) load_tx(8'($urandom));
         nw = $urandom_range(1, 3);
         m_words.delete();
         for (int k = 0; k < nw; k++) m_words.push_back(8'($urandom));
         sb = ($urandom_range(0, 3) == 0) ? 8 * $urandom_range(0, nw - 1) + $urandom_range(1, 7) : -1;
         frame($sformatf("rnd%0d", it), sb, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
